// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage: 32-cycle shift-add
// multiply and restoring divide on operand magnitudes, with sign fix-up at the end.
module ex_muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  done_rd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic [4:0]  done_rd_q, done_rd_d;

  logic        a_signed, b_signed, sa, sb, neg_in;
  logic [31:0] mag_a, mag_b;
  logic        div_by_zero, div_ovf;
  logic [32:0] mul_sum;
  logic [63:0] mul_acc, prod_fix;
  logic [32:0] div_shift, div_rem;
  logic        div_fit;
  logic [31:0] div_quo, quo_fix, rem_fix, final_res;

  always_comb begin
    b_signed    = (funct3 == 3'b000) | (funct3 == 3'b001) |
                  (funct3 == 3'b100) | (funct3 == 3'b110);
    a_signed    = b_signed | (funct3 == 3'b010);
    sa          = a_signed & rs1_val[31];
    sb          = b_signed & rs2_val[31];
    mag_a       = sa ? (~rs1_val + 32'd1) : rs1_val;
    mag_b       = sb ? (~rs2_val + 32'd1) : rs2_val;
    div_by_zero = funct3[2] & (rs2_val == 32'd0);
    div_ovf     = funct3[2] & ~funct3[0] & (rs1_val == 32'h8000_0000) &
                  (rs2_val == 32'hFFFF_FFFF);
    // Single negate flag: product sign, quotient sign, or dividend sign for REM.
    if (funct3[2]) begin
      neg_in = funct3[0] ? 1'b0 : (funct3[1] ? sa : (sa ^ sb));
    end else begin
      neg_in = sa ^ sb;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    mul_acc   = {mul_sum, acc_q[31:1]};
    div_shift = {rem_q[31:0], acc_q[31]};
    div_fit   = (div_shift >= {1'b0, b_q});
    div_rem   = div_fit ? (div_shift - {1'b0, b_q}) : div_shift;
    div_quo   = {acc_q[30:0], div_fit};
    prod_fix  = neg_q ? (~mul_acc + 64'd1) : mul_acc;
    quo_fix   = neg_q ? (~div_quo + 32'd1) : div_quo;
    rem_fix   = neg_q ? (~div_rem[31:0] + 32'd1) : div_rem[31:0];
    case (funct3_q)
      3'b000:         final_res = prod_fix[31:0];
      3'b001, 3'b010,
      3'b011:         final_res = prod_fix[63:32];
      3'b100, 3'b101: final_res = quo_fix;
      default:        final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    result_d  = result_q;
    done_d    = 1'b0;
    done_rd_d = done_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          funct3_d = funct3;
          rd_d     = rd;
          a_d      = mag_a;
          b_d      = mag_b;
          neg_d    = neg_in;
          count_d  = 5'd0;
          if (div_by_zero || div_ovf) begin
            if (div_by_zero) begin
              result_d = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
            end else begin
              result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
            end
            done_d    = 1'b1;
            done_rd_d = rd;
            state_d   = ST_DONE;
          end else begin
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            acc_d   = funct3[2] ? {32'd0, mag_a} : {32'd0, mag_b};
            rem_d   = 33'd0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = funct3_q[2] ? {32'd0, div_quo} : mul_acc;
          rem_d   = funct3_q[2] ? div_rem : rem_q;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            result_d  = final_res;
            done_d    = 1'b1;
            done_rd_d = rd_q;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= 5'd0;
      funct3_q  <= 3'd0;
      rd_q      <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      neg_q     <= 1'b0;
      acc_q     <= 64'd0;
      rem_q     <= 33'd0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
      done_rd_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
      done_rd_q <= done_rd_d;
    end
  end

  assign stall   = ((state_q == ST_IDLE) && start && !kill) || (state_q == ST_RUN);
  assign done    = done_q;
  assign result  = result_q;
  assign done_rd = done_rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized bench for ex_muldiv_unit with a result scoreboard.
module tb_ex_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  done_rd;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  ex_muldiv_unit dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .kill    (kill),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd      (rd),
    .stall   (stall),
    .done    (done),
    .result  (result),
    .done_rd (done_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built on native 64-bit arithmetic and SV signed division.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f3 == 3'b011) ? {32'd0, a} : {{32{a[31]}}, a};
    eb = (f3 == 3'b010 || f3 == 3'b011) ? {32'd0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    case (f3)
      3'b000: model = p[31:0];
      3'b001, 3'b010, 3'b011: model = p[63:32];
      3'b100: model = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                      $unsigned($signed(a) / $signed(b));
      3'b101: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: model = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                      $unsigned($signed(a) % $signed(b));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] exp, input int lat);
    exp_t e;
    int   cyc;
    bit   got;
    exp_q.push_back('{res: exp, rd: r});
    start   = 1'b1;
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    rd      = r;
    cyc     = 0;
    got     = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clock);
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        chk("stall_busy", {31'd0, stall}, 32'd1);
        @(posedge clock);
        #1;
        cyc++;
        rs1_val = $urandom;
        rs2_val = $urandom;
        funct3  = 3'($urandom);
        rd      = 5'($urandom);
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      chk("timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", cyc, lat);
      chk("stall_done", {31'd0, stall}, 32'd0);
      chk("result", result, e.res);
      chk("done_rd", {27'd0, done_rd}, {27'd0, e.rd});
      $display("[TB] op f3=%0d a=%h b=%h rd=%0d -> result=%h done_rd=%0d cycle=%0d",
               f3, a, b, r, result, done_rd, cyc);
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      exp_lat = 1;
    else
      exp_lat = 33;
  endfunction

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    kill    = 1'b0;
    funct3  = 3'd0;
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    rd      = 5'd0;
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_done_rd", {27'd0, done_rd}, 32'd0);
    #10 reset = 1'b0;
    @(posedge clock);
    #1;

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 33);
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 33);
    do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF, 33);
    idle(2);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    do_op(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 33);
    do_op(3'b111, 32'd100, 32'd7, 5'd10, 32'd2, 33);
    do_op(3'b101, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    do_op(3'b110, 32'd5, 32'd0, 5'd12, 32'd5, 1);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1);
    do_op(3'b111, 32'd123, 32'd10, 5'd15, 32'd3, 33);

    // Kill a MUL in cycle 10; result must keep the last value (3).
    start   = 1'b1;
    funct3  = 3'b000;
    rs1_val = 32'd9;
    rs2_val = 32'd9;
    rd      = 5'd16;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("kill_busy", {31'd0, stall}, 32'd1);
      @(posedge clock);
      #1;
    end
    kill = 1'b1;
    @(negedge clock);
    chk("kill_cycle_stall", {31'd0, stall}, 32'd1);
    @(posedge clock);
    #1;
    kill  = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("kill_stall_low", {31'd0, stall}, 32'd0);
      chk("kill_no_done", {31'd0, done}, 32'd0);
      @(posedge clock);
      #1;
    end
    chk("kill_result_hold", result, 32'd3);
    $display("[TB] kill f3=0 rd=16 -> aborted, result=%h", result);
    do_op(3'b000, 32'd9, 32'd9, 5'd17, 32'd81, 33);

    // Asynchronous reset in cycle 15 of a DIVU.
    start   = 1'b1;
    funct3  = 3'b101;
    rs1_val = 32'd1000;
    rs2_val = 32'd3;
    rd      = 5'd18;
    idle(15);
    reset = 1'b1;
    start = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_done_rd", {27'd0, done_rd}, 32'd0);
    $display("[TB] reset mid-run -> result=%h done_rd=%0d", result, done_rd);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    do_op(3'b101, 32'd1000, 32'd3, 5'd19, 32'd333, 33);

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom);
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 1000)) : $urandom);
      if (i == 5) begin
        rf3 = 3'b100;
        ra  = 32'h8000_0000;
        rb  = 32'hFFFF_FFFF;
      end
      if (i == 3) rf3[2] = 1'b1;
      do_op(rf3, ra, rb, 5'(i + 20), model(rf3, ra, rb), exp_lat(rf3, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
